arp_reply_ctrl: RTL and testbench

- Queues validated ARP requests, from the receive-side ARP parser's completion pulse and sender address fields, and builds the ARP reply for each one.
- Requests the shared Ethernet transmit path through a req/gnt handshake, then streams each reply as seven 32-bit payload words with start/end markers.
- Sits between the ARP receive parser and the MAC transmit arbiter.

---
 rtl/arp_pkg.sv | 27 ++
 rtl/arp_req_fifo.sv | 61 ++++++
 rtl/arp_reply_ctrl.sv | 138 +++++++++++++
 tb/tb_arp_reply_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// ARP reply path shared definitions.
// Protocol constants, queue entry layout and reply FSM states.
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
    localparam logic [15:0] ARP_OP_REQ     = 16'd1;
    localparam logic [15:0] ARP_OP_REPLY   = 16'd2;
    localparam logic [7:0]  ARP_HLEN       = 8'd6;
    localparam logic [7:0]  ARP_PLEN       = 8'd4;
    localparam int          ARP_WORDS      = 7;
    localparam logic [2:0]  ARP_LAST       = 3'(ARP_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND,
        ST_GAP
    } arp_state_t;

    typedef struct packed {
        logic [47:0] mac;
        logic [31:0] ip;
    } arp_entry_t;

endpackage

// File: rtl/arp_req_fifo.sv
// Pending ARP request queue.
// A full queue still accepts a push when the head is popped in the same cycle.
module arp_req_fifo
    import arp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  arp_entry_t din,
    input  logic       pop,
    output arp_entry_t dout,
    output logic [4:0] count,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    arp_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr;
    logic          rd;

    assign full  = (count == 5'(DEPTH));
    assign empty = (count == 5'd0);
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign dout  = mem[rd_ptr];

    // Storage array, written on every accepted push.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr && !rd) begin
                count <= count + 5'd1;
            end else if (rd && !wr) begin
                count <= count - 5'd1;
            end
        end
    end

endmodule

// File: rtl/arp_reply_ctrl.sv
// ARP reply controller: queues requests, arbitrates for TX, streams replies.
// Reply words are muxed from shadow registers captured when a request is popped.
module arp_reply_ctrl
    import arp_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] dev_mac_addr_i,
    input  logic [31:0] dev_ip_addr_i,
    input  logic        arp_vld_i,
    input  logic [47:0] sender_haddr_i,
    input  logic [31:0] sender_paddr_i,
    output logic        tx_req_o,
    input  logic        tx_gnt_i,
    input  logic        tx_rdy_i,
    output logic        tx_op_o,
    output logic        tx_op_st_o,
    output logic        tx_op_end_o,
    output logic [31:0] tx_data_o,
    output logic [47:0] tx_dest_addr_o,
    output logic [15:0] tx_prot_type_o,
    output logic [4:0]  pend_cnt_o,
    output logic        drop_o
);

    arp_state_t  state;
    logic [2:0]  word_cnt;
    logic [3:0]  gap_cnt;
    logic [47:0] tgt_mac;
    logic [31:0] tgt_ip;
    logic [47:0] own_mac;
    logic [31:0] own_ip;
    arp_entry_t  head;
    arp_entry_t  req_in;
    logic        q_full;
    logic        q_empty;
    logic        pop;

    assign req_in = '{mac: sender_haddr_i, ip: sender_paddr_i};
    assign pop    = (state == ST_IDLE) && !q_empty;
    assign drop_o = arp_vld_i && q_full && !pop;

    arp_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (arp_vld_i),
        .din   (req_in),
        .pop   (pop),
        .dout  (head),
        .count (pend_cnt_o),
        .full  (q_full),
        .empty (q_empty)
    );

    assign tx_op_st_o     = tx_op_o && (word_cnt == 3'd0);
    assign tx_op_end_o    = tx_op_o && (word_cnt == ARP_LAST);
    assign tx_dest_addr_o = tgt_mac;
    assign tx_prot_type_o = ETH_TYPE_ARP;

    // Reply sequencer: pop, request TX, stream words, then hold off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            word_cnt <= 3'd0;
            gap_cnt  <= 4'd0;
            tgt_mac  <= '0;
            tgt_ip   <= '0;
            own_mac  <= '0;
            own_ip   <= '0;
            tx_req_o <= 1'b0;
            tx_op_o  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        tgt_mac  <= head.mac;
                        tgt_ip   <= head.ip;
                        own_mac  <= dev_mac_addr_i;
                        own_ip   <= dev_ip_addr_i;
                        tx_req_o <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tx_gnt_i) begin
                        word_cnt <= 3'd0;
                        tx_op_o  <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_rdy_i) begin
                        if (word_cnt == ARP_LAST) begin
                            word_cnt <= 3'd0;
                            gap_cnt  <= 4'd0;
                            tx_req_o <= 1'b0;
                            tx_op_o  <= 1'b0;
                            state    <= ST_GAP;
                        end else begin
                            word_cnt <= word_cnt + 3'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'(GAP_CYC)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Payload word select; quiet outside the streaming state.
    always_comb begin
        tx_data_o = 32'd0;
        if (state == ST_SEND) begin
            case (word_cnt)
                3'd0: tx_data_o = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4};
                3'd1: tx_data_o = {ARP_HLEN, ARP_PLEN, ARP_OP_REPLY};
                3'd2: tx_data_o = own_mac[47:16];
                3'd3: tx_data_o = {own_mac[15:0], own_ip[31:16]};
                3'd4: tx_data_o = {own_ip[15:0], tgt_mac[47:32]};
                3'd5: tx_data_o = tgt_mac[31:0];
                3'd6: tx_data_o = tgt_ip;
                default: tx_data_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_arp_reply_ctrl.sv
// Bench for arp_reply_ctrl.
// Random traffic against a byte-level ARP reply model and scoreboard.
module tb_arp_reply_ctrl;

    localparam int DEPTH   = 4;
    localparam int GAP_CYC = 2;

    logic        clk;
    logic        rst_n;
    logic [47:0] dev_mac_addr_i;
    logic [31:0] dev_ip_addr_i;
    logic        arp_vld_i;
    logic [47:0] sender_haddr_i;
    logic [31:0] sender_paddr_i;
    logic        tx_req_o;
    logic        tx_gnt_i;
    logic        tx_rdy_i;
    logic        tx_op_o;
    logic        tx_op_st_o;
    logic        tx_op_end_o;
    logic [31:0] tx_data_o;
    logic [47:0] tx_dest_addr_o;
    logic [15:0] tx_prot_type_o;
    logic [4:0]  pend_cnt_o;
    logic        drop_o;

    arp_reply_ctrl #(
        .DEPTH   (DEPTH),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dev_mac_addr_i (dev_mac_addr_i),
        .dev_ip_addr_i  (dev_ip_addr_i),
        .arp_vld_i      (arp_vld_i),
        .sender_haddr_i (sender_haddr_i),
        .sender_paddr_i (sender_paddr_i),
        .tx_req_o       (tx_req_o),
        .tx_gnt_i       (tx_gnt_i),
        .tx_rdy_i       (tx_rdy_i),
        .tx_op_o        (tx_op_o),
        .tx_op_st_o     (tx_op_st_o),
        .tx_op_end_o    (tx_op_end_o),
        .tx_data_o      (tx_data_o),
        .tx_dest_addr_o (tx_dest_addr_o),
        .tx_prot_type_o (tx_prot_type_o),
        .pend_cnt_o     (pend_cnt_o),
        .drop_o         (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_words[$];
    logic [47:0] exp_dest[$];

    // Reference: lay out the 28-byte ARP reply and cut it into words.
    function automatic void add_reply(input logic [47:0] dm,
                                      input logic [31:0] di,
                                      input logic [47:0] tm,
                                      input logic [31:0] ti);
        logic [7:0] b [28];
        b[0] = 8'h00; b[1] = 8'h01;
        b[2] = 8'h08; b[3] = 8'h00;
        b[4] = 8'd6;  b[5] = 8'd4;
        b[6] = 8'h00; b[7] = 8'h02;
        for (int i = 0; i < 6; i++) begin
            b[8 + i]  = 8'(dm >> (8 * (5 - i)));
            b[18 + i] = 8'(tm >> (8 * (5 - i)));
        end
        for (int i = 0; i < 4; i++) begin
            b[14 + i] = 8'(di >> (8 * (3 - i)));
            b[24 + i] = 8'(ti >> (8 * (3 - i)));
        end
        for (int k = 0; k < 7; k++) begin
            exp_words.push_back({b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]});
        end
        exp_dest.push_back(tm);
    endfunction

    int rdy_mode = 0;
    bit gnt_en   = 1'b1;
    int gdly     = 0;
    int gwait    = 0;

    // Arbiter stand-in: grant after a random delay, hold while requested.
    initial begin
        tx_gnt_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!tx_req_o) begin
                tx_gnt_i = 1'b0;
                gwait    = 0;
                gdly     = $urandom_range(0, 4);
            end else if (gnt_en) begin
                if (gwait >= gdly) tx_gnt_i = 1'b1;
                else gwait++;
            end
        end
    end

    // Transmitter ready pattern.
    initial begin
        tx_rdy_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: tx_rdy_i = 1'b1;
                1: tx_rdy_i = 1'($urandom_range(0, 1));
                default: tx_rdy_i = ~tx_rdy_i;
            endcase
        end
    end

    int mon_idx = 0;
    int drops   = 0;
    int replies = 0;
    bit granted = 1'b0;

    // Monitor: scoreboard every accepted word.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_idx = 0;
                granted = 1'b0;
            end else begin
                if (drop_o) drops++;
                if (tx_req_o && tx_gnt_i && !tx_op_o) granted = 1'b1;
                if (tx_op_o) begin
                    check("op_needs_gnt", 64'(granted), 64'd1);
                    check("op_needs_req", 64'(tx_req_o), 64'd1);
                    if (tx_rdy_i) begin
                        check("st", 64'(tx_op_st_o), 64'(mon_idx == 0));
                        check("end", 64'(tx_op_end_o), 64'(mon_idx == 6));
                        check("word_expected", 64'(exp_words.size() != 0), 64'd1);
                        if (exp_words.size() != 0) begin
                            check("data", 64'(tx_data_o), 64'(exp_words.pop_front()));
                            check("dest", 64'(tx_dest_addr_o), 64'(exp_dest[0]));
                        end
                        if (mon_idx == 6) begin
                            mon_idx = 0;
                            granted = 1'b0;
                            replies++;
                            if (exp_dest.size() != 0) void'(exp_dest.pop_front());
                        end else begin
                            mon_idx++;
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [47:0] m, input logic [31:0] ip,
                        input bit acc);
        arp_vld_i      = 1'b1;
        sender_haddr_i = m;
        sender_paddr_i = ip;
        if (acc) add_reply(dev_mac_addr_i, dev_ip_addr_i, m, ip);
        @(posedge clk);
        #1;
        arp_vld_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((exp_dest.size() != 0 || tx_req_o || pend_cnt_o != 5'd0)
               && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_left", 64'(exp_dest.size()), 64'd0);
        cyc(GAP_CYC + 3);
    endtask

    function automatic logic [47:0] rmac();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic overflow(input int k);
        int d0;
        int r0;
        int acc_n;
        acc_n  = (k < DEPTH) ? k : DEPTH;
        gnt_en = 1'b0;
        push(rmac(), $urandom, 1'b1);
        cyc(3);
        d0 = drops;
        for (int i = 0; i < k; i++) push(rmac(), $urandom, i < DEPTH);
        cyc(1);
        check("ovf_pend", 64'(pend_cnt_o), 64'(acc_n));
        check("ovf_drops", 64'(drops - d0), 64'(k - acc_n));
        r0     = replies;
        gnt_en = 1'b1;
        drain(1500);
        check("ovf_replies", 64'(replies - r0), 64'(acc_n + 1));
    endtask

    int n;
    int cnt_a;
    int cnt_b;
    int r0;
    int d0;

    initial begin
        rst_n          = 1'b0;
        arp_vld_i      = 1'b0;
        sender_haddr_i = '0;
        sender_paddr_i = '0;
        dev_mac_addr_i = '0;
        dev_ip_addr_i  = '0;
        #2;
        check("rst_req", 64'(tx_req_o), 64'd0);
        check("rst_op", 64'(tx_op_o), 64'd0);
        check("rst_st_end", 64'({tx_op_st_o, tx_op_end_o}), 64'd0);
        check("rst_data", 64'(tx_data_o), 64'd0);
        check("rst_dest", 64'(tx_dest_addr_o), 64'd0);
        check("rst_pend", 64'(pend_cnt_o), 64'd0);
        check("rst_drop", 64'(drop_o), 64'd0);
        check("prot_type", 64'(tx_prot_type_o), 64'h0806);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Single request with minimum request latency.
        dev_mac_addr_i = 48'h020000000001;
        dev_ip_addr_i  = 32'hC0A80001;
        push(48'h001122334455, 32'hC0A80064, 1'b1);
        n = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_req_o) break;
            n++;
        end
        check("req_latency", 64'(n), 64'd2);
        check("dest_in_req", 64'(tx_dest_addr_o), 64'h001122334455);
        r0 = replies;
        drain(200);
        check("single_reply", 64'(replies - r0), 64'd1);

        // Toggling ready.
        rdy_mode = 2;
        r0 = replies;
        push(rmac(), $urandom, 1'b1);
        drain(300);
        check("bp_reply", 64'(replies - r0), 64'd1);
        rdy_mode = 0;

        // Grant withheld for 20 cycles.
        gnt_en = 1'b0;
        push(rmac(), $urandom, 1'b1);
        cyc(3);
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_op_o) cnt_a++;
            if (!tx_req_o) cnt_b++;
        end
        check("nogrant_op", 64'(cnt_a), 64'd0);
        check("nogrant_req_low", 64'(cnt_b), 64'd0);
        gnt_en = 1'b1;
        cyc(1);
        drain(200);

        // Queue overflow.
        overflow(5);
        overflow($urandom_range(2, 7));

        // Back-to-back replies: gap plus the pop cycle.
        dev_mac_addr_i = rmac();
        dev_ip_addr_i  = $urandom;
        push(rmac(), $urandom, 1'b1);
        push(rmac(), $urandom, 1'b1);
        cnt_a = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx_op_o && tx_op_end_o && tx_rdy_i) break;
            cnt_a++;
        end
        check("b2b_end_seen", 64'(cnt_a < 100), 64'd1);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (tx_req_o) break;
            n++;
        end
        check("b2b_idle_cycles", 64'(n), 64'(GAP_CYC + 2));
        #1;
        drain(300);

        // Random traffic.
        d0 = drops;
        for (int r = 0; r < 10; r++) begin
            int nreq;
            dev_mac_addr_i = rmac();
            dev_ip_addr_i  = $urandom;
            rdy_mode       = $urandom_range(0, 1);
            nreq           = $urandom_range(1, 3);
            r0             = replies;
            for (int i = 0; i < nreq; i++) begin
                push(rmac(), $urandom, 1'b1);
                cyc($urandom_range(0, 12));
            end
            drain(1000);
            check("rand_replies", 64'(replies - r0), 64'(nreq));
        end
        check("rand_drops", 64'(drops - d0), 64'd0);
        rdy_mode = 0;

        // Reset in the middle of a stream.
        push(rmac(), $urandom, 1'b1);
        push(rmac(), $urandom, 1'b1);
        push(rmac(), $urandom, 1'b1);
        cnt_a = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx_op_o && tx_op_st_o) break;
            cnt_a++;
        end
        check("rst_st_seen", 64'(cnt_a < 100), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_req", 64'(tx_req_o), 64'd0);
        check("arst_op", 64'(tx_op_o), 64'd0);
        check("arst_data", 64'(tx_data_o), 64'd0);
        check("arst_dest", 64'(tx_dest_addr_o), 64'd0);
        check("arst_pend", 64'(pend_cnt_o), 64'd0);
        exp_words.delete();
        exp_dest.delete();
        cyc(3);
        rst_n = 1'b1;
        cnt_a = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_req_o || tx_op_o) cnt_a++;
        end
        check("post_rst_quiet", 64'(cnt_a), 64'd0);
        check("post_rst_pend", 64'(pend_cnt_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

endmodule
